// File: rtl/branch_predictor_pkg.sv
// Shared branch-path definitions: resolution opcodes, 2-bit counter encodings
// and the update payload sent from execute to the fetch-stage predictor.
package branch_predictor_pkg;

   localparam int unsigned PC_W  = 32;
   localparam int unsigned OP_W  = 6;
   localparam int unsigned CTR_W = 2;

   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OP_W-1:0] OP_BGTZ = 6'b000111;

   localparam logic [CTR_W-1:0] CTR_SNT = 2'd0;
   localparam logic [CTR_W-1:0] CTR_WNT = 2'd1;
   localparam logic [CTR_W-1:0] CTR_WT  = 2'd2;
   localparam logic [CTR_W-1:0] CTR_ST  = 2'd3;

   localparam logic [PC_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [PC_W-1:0] pc;
      logic            taken;
      logic [PC_W-1:0] target;
      logic            pred_taken;
   } upd_t;

   // Only conditional branches train the predictor.
   function automatic logic is_cond_branch(input logic [OP_W-1:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch prediction / execute resolution bus between the core and the predictor.
interface branch_predictor_if;
   import branch_predictor_pkg::*;

   logic [PC_W-1:0] fetch_pc;
   logic            pred_taken;
   logic [PC_W-1:0] pred_target;
   logic            pred_hit;
   logic            upd_valid;
   upd_t            upd;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;

   modport master (
      output fetch_pc, upd_valid, upd,
      input  pred_taken, pred_target, pred_hit, stat_branches, stat_mispredicts
   );

   modport slave (
      input  fetch_pc, upd_valid, upd,
      output pred_taken, pred_target, pred_hit, stat_branches, stat_mispredicts
   );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: taken counts up to ST, not-taken down to SNT.
module branch_predictor_sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_next_c
);

   always_comb begin
      ctr_next_c = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next_c = ctr + CTR_W'(1);
      end else begin
         if (ctr != CTR_SNT) ctr_next_c = ctr - CTR_W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped BTB predictor with 2-bit direction counters,
// trained by execute-stage branch resolution, plus hit/mispredict stats.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 6
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bus
);

   localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
   localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

   logic                  valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [PC_W-1:0]       target_q [ENTRIES];
   logic [CTR_W-1:0]      ctr_q    [ENTRIES];
   logic [31:0]           branches_q;
   logic [31:0]           mispredicts_q;

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  upd_accept;
   logic                  upd_hit;
   logic [CTR_W-1:0]      ctr_next;
   logic                  unused_pc_lsb;

   assign fetch_idx = bus.fetch_pc[INDEX_BITS+1:2];
   assign fetch_tag = bus.fetch_pc[31:INDEX_BITS+2];
   assign upd_idx   = bus.upd.pc[INDEX_BITS+1:2];
   assign upd_tag   = bus.upd.pc[31:INDEX_BITS+2];
   assign unused_pc_lsb = ^bus.upd.pc[1:0];

   // Prediction reads registered state only; no bypass from a same-cycle update.
   assign bus.pred_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign bus.pred_taken  = bus.pred_hit && ctr_q[fetch_idx][1];
   assign bus.pred_target = bus.pred_taken ? target_q[fetch_idx] : bus.fetch_pc + PC_INC;

   assign bus.stat_branches    = branches_q;
   assign bus.stat_mispredicts = mispredicts_q;

   assign upd_accept = bus.upd_valid && is_cond_branch(bus.upd.op);
   assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   branch_predictor_sat_counter2 u_sat_counter2 (
      .ctr        (ctr_q[upd_idx]),
      .taken      (bus.upd.taken),
      .ctr_next_c (ctr_next)
   );

   // BTB training and statistics; reset wins over a concurrent update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else if (upd_accept) begin
         branches_q <= branches_q + 32'd1;
         if (bus.upd.pred_taken != bus.upd.taken) mispredicts_q <= mispredicts_q + 32'd1;
         if (upd_hit) begin
            ctr_q[upd_idx] <= ctr_next;
            if (bus.upd.taken) target_q[upd_idx] <= bus.upd.target;
         end else if (bus.upd.taken) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bus.upd.target;
            ctr_q[upd_idx]    <= CTR_WT;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (INDEX_BITS=6).
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   typedef struct {
      string       tag;
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   exp_t sb[$];

   branch_predictor_if bus ();

   branch_predictor #(.INDEX_BITS(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic drive_upd(input logic [5:0] op, input logic [31:0] pc, input logic taken,
                            input logic [31:0] target, input logic pt);
      bus.upd_valid       = 1'b1;
      bus.upd.op          = op;
      bus.upd.pc          = pc;
      bus.upd.taken       = taken;
      bus.upd.target      = target;
      bus.upd.pred_taken  = pt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
   endtask

   task automatic upd(input logic [5:0] op, input logic [31:0] pc, input logic taken,
                      input logic [31:0] target, input logic pt);
      drive_upd(op, pc, taken, target, pt);
      tick();
   endtask

   task automatic expect_pred(input string tag, input logic [31:0] pc, input logic hit,
                              input logic taken, input logic [31:0] target,
                              input logic [31:0] br, input logic [31:0] mp);
      exp_t e;
      bus.fetch_pc = pc;
      sb.push_back('{tag, hit, taken, target, br, mp});
      #1;
      e = sb.pop_front();
      tests++;
      assert (bus.pred_hit === e.hit) else begin
         fails++; $error("FAIL %s hit: got %0h want %0h", e.tag, bus.pred_hit, e.hit);
      end
      tests++;
      assert (bus.pred_taken === e.taken) else begin
         fails++; $error("FAIL %s taken: got %0h want %0h", e.tag, bus.pred_taken, e.taken);
      end
      tests++;
      assert (bus.pred_target === e.target) else begin
         fails++; $error("FAIL %s target: got %08h want %08h", e.tag, bus.pred_target, e.target);
      end
      tests++;
      assert (bus.stat_branches === e.br) else begin
         fails++; $error("FAIL %s branches: got %0d want %0d", e.tag, bus.stat_branches, e.br);
      end
      tests++;
      assert (bus.stat_mispredicts === e.mp) else begin
         fails++; $error("FAIL %s mispredicts: got %0d want %0d", e.tag, bus.stat_mispredicts, e.mp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.fetch_pc  = 32'h0040_0010;
      bus.upd_valid = 1'b0;
      bus.upd       = '0;
      tick();
      tick();
      rst = 1'b0;

      expect_pred("reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, 0, 0);

      upd(OP_BEQ, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
      expect_pred("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1, 1);

      for (int i = 0; i < 3; i++) upd(OP_BEQ, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1);
      expect_pred("sat_hi", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 4, 1);

      upd(OP_BEQ, 32'h0040_0010, 1'b0, 32'h0000_0000, 1'b1);
      expect_pred("nt_once", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 5, 2);

      upd(OP_BEQ, 32'h0040_0010, 1'b0, 32'h0000_0000, 1'b1);
      expect_pred("nt_twice", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014, 6, 3);

      upd(OP_BEQ, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
      expect_pred("alias_miss", 32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014, 7, 4);
      expect_pred("orig_hit", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 7, 4);

      upd(OP_BNE, 32'h0040_1010, 1'b1, 32'h0040_2000, 1'b0);
      expect_pred("alias_repl", 32'h0040_1010, 1'b1, 1'b1, 32'h0040_2000, 8, 5);
      expect_pred("orig_evict", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, 8, 5);

      upd(6'b000010, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
      expect_pred("jump_ign", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, 8, 5);
      expect_pred("jump_keep", 32'h0040_1010, 1'b1, 1'b1, 32'h0040_2000, 8, 5);

      drive_upd(OP_BEQ, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
      bus.upd_valid = 1'b0;
      tick();
      expect_pred("nvalid_ign", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014, 8, 5);

      upd(OP_BGTZ, 32'h0050_0020, 1'b0, 32'h0000_0000, 1'b0);
      expect_pred("nt_miss", 32'h0050_0020, 1'b0, 1'b0, 32'h0050_0024, 9, 5);

      drive_upd(OP_BGTZ, 32'h0050_0020, 1'b1, 32'h0060_0000, 1'b0);
      expect_pred("same_old", 32'h0050_0020, 1'b0, 1'b0, 32'h0050_0024, 9, 5);
      tick();
      expect_pred("same_new", 32'h0050_0020, 1'b1, 1'b1, 32'h0060_0000, 10, 6);

      rst = 1'b1;
      drive_upd(OP_BEQ, 32'h0070_0000, 1'b1, 32'h0070_0400, 1'b0);
      tick();
      rst = 1'b0;
      expect_pred("rst_a", 32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014, 0, 0);
      expect_pred("rst_b", 32'h0050_0020, 1'b0, 1'b0, 32'h0050_0024, 0, 0);
      expect_pred("rst_upd", 32'h0070_0000, 1'b0, 1'b0, 32'h0070_0004, 0, 0);
      expect_pred("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 0, 0);

      upd(OP_BEQ, 32'h0070_0000, 1'b1, 32'h0070_0400, 1'b1);
      expect_pred("post_rst", 32'h0070_0000, 1'b1, 1'b1, 32'h0070_0400, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
